fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_REQ, 4, number of producers
- DW, 8, data width
- MAX_BURST, 4, maximum words per grant
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  producer i has a word ready
- req_data  in  N_REQ*DW  producer i word at bits [DW*i+DW-1 : DW*i]
- last  in  N_REQ  producer i word is the final word of its packet
- fifo_full  in  1  full flag from downstream 8-deep FIFO
- gnt  out  N_REQ  registered one-hot grant
- ack  out  N_REQ  word of producer i accepted this cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_data_in  out  DW  FIFO write data
- busy  out  1  FSM not in IDLE
- owner  out  2  index of current grant holder
- word_cnt  out  16  total words written since reset

Function
REQ-003 The FSM SHALL have two states: IDLE and XFER.
REQ-004 In IDLE with req != 0, the next edge SHALL select the first requester with req set, searching round-robin from (last_owner+1) mod N_REQ, load owner, set gnt[owner], clear burst_cnt, and enter XFER.
REQ-005 In IDLE with req == 0, the FSM SHALL stay in IDLE with gnt = 0.
REQ-006 In XFER, accept SHALL be combinational: accept = req[owner] && !fifo_full.
REQ-007 fifo_wr_en SHALL equal accept; fifo_data_in SHALL equal the owner's req_data slice when accept is 1, else 0.
REQ-008 ack[owner] SHALL equal accept; all other ack bits SHALL be 0.
REQ-009 The first word SHALL be written in the cycle gnt first asserts, giving 1-cycle latency from req to first write.
REQ-010 On each accept edge, burst_cnt SHALL increment and word_cnt SHALL increment, wrapping 0xFFFF -> 0x0000.
REQ-011 XFER SHALL release to IDLE at the next edge, clearing gnt and recording last_owner = owner, when any of the following holds:
- accept && last[owner]
- accept && burst_cnt == MAX_BURST-1
- req[owner] == 0
REQ-012 With fifo_full = 1 in XFER, the block SHALL hold gnt, owner and burst_cnt, keep ack = 0 and fifo_wr_en = 0, and SHALL NOT release unless req[owner] drops.
REQ-013 After any release, at least one IDLE cycle SHALL pass before the next grant, whether to the same or another requester.
REQ-014 With a single requester persistently requesting, that requester SHALL be regranted after the IDLE cycle.
REQ-015 Requests from non-owners SHALL be ignored during XFER; gnt SHALL never have more than one bit set.
REQ-016 busy SHALL be 1 in XFER and 0 in IDLE; owner SHALL hold its value while in IDLE.

Reset
REQ-017 When rst = 1 at a clock edge, the block SHALL enter IDLE and clear the following to 0: gnt, owner, burst_cnt, word_cnt and busy. It SHALL set last_owner = N_REQ-1 so that requester 0 has first priority.
REQ-018 While rst = 1, fifo_wr_en and ack SHALL be 0, regardless of req.
REQ-019 Reset asserted mid-burst SHALL abort the burst at that edge, and no further writes SHALL occur.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then req=0001, req_data[7:0]=0xA5, last=0001 -> gnt=0001 next cycle; fifo_wr_en=1 with data 0xA5 that cycle; release; word_cnt=1.
- req=1111 held, last=0 -> grant order 0,1,2,3,0; each burst exactly 4 writes; one IDLE cycle between bursts; word_cnt=16 after 4 bursts.
- Owner 2 mid-burst, fifo_full=1 for 3 cycles -> fifo_wr_en=0, ack=0, gnt=0100 held, burst_cnt frozen; writes resume when full drops; burst totals 4 words.
- Owner 1 drops req after 2 words -> release next edge; last_owner=1; next grant goes to 2 if requesting.
- rst pulsed during burst of owner 3 -> next cycle gnt=0, busy=0, word_cnt=0; first subsequent grant goes to requester 0.
- word_cnt preloaded by 65535 writes, one more write -> word_cnt wraps to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that moves producer words into a downstream FIFO.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]  last,
  input  logic              fifo_full,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  ack,
  output logic              fifo_wr_en,
  output logic [DW-1:0]     fifo_data_in,
  output logic              busy,
  output logic [1:0]        owner,
  output logic [15:0]       word_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  logic [0:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d, last_owner_q, last_owner_d, pick;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             accept, rel;
  // Descending scan so the closest requester after last_owner wins.
  always_comb begin
    pick = last_owner_q;
    for (int i = N_REQ; i >= 1; i--)
      if (req[(int'(last_owner_q) + i) % N_REQ]) pick = 2'((int'(last_owner_q) + i) % N_REQ);
  end
  assign accept       = (state_q == XFER) && req[owner_q] && !fifo_full && !rst;
  assign rel          = !req[owner_q] || (accept && (last[owner_q] || burst_q == BW'(MAX_BURST-1)));
  assign fifo_wr_en   = accept;
  assign fifo_data_in = accept ? req_data[DW*owner_q +: DW] : '0;
  assign ack          = accept ? ONE << owner_q : '0;
  assign gnt          = gnt_q;
  assign busy         = (state_q == XFER);
  assign owner        = owner_q;
  assign word_cnt     = word_cnt_q;
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    burst_d      = burst_q;
    word_cnt_d   = word_cnt_q + 16'(accept);
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = XFER;
        owner_d = pick;
        gnt_d   = ONE << pick;
        burst_d = '0;
      end
    end else if (rel) begin
      state_d      = IDLE;
      gnt_d        = '0;
      last_owner_d = owner_q;
    end else begin
      burst_d = accept ? burst_q + 1'b1 : burst_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= 2'(N_REQ-1);
      gnt_q        <= '0;
      burst_q      <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      burst_q      <= burst_d;
      word_cnt_q   <= word_cnt_d;
    end
  end
endmodule
